uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART receiver.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam int unsigned DATA_BITS            = 8;
  localparam int unsigned BIT_IDX_W            = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // Double-register the asynchronous input; both stages reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, strobes get_bit per data bit and
// packet_done when a frame with a valid stop bit completes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       serial_dat_in,
  output logic       get_bit,
  output logic       packet_done,
  output logic [7:0] data
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

  logic rx;

  rx_state_t             state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [7:0]            sh_q, sh_d;
  logic [7:0]            data_d;
  logic                  get_bit_d, packet_done_d;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (serial_dat_in),
    .q    (rx)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      sh_q        <= 8'h00;
      data        <= 8'h00;
      get_bit     <= 1'b0;
      packet_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      sh_q        <= sh_d;
      data        <= data_d;
      get_bit     <= get_bit_d;
      packet_done <= packet_done_d;
    end
  end

  // Next-state, counter and output-strobe decode.
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    sh_d          = sh_q;
    data_d        = data;
    get_bit_d     = 1'b0;
    packet_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx) state_d = START;
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          // A start bit that has gone high by mid-bit was a glitch.
          state_d   = rx ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d       = '0;
          sh_d[bit_idx_q] = rx;
          get_bit_d       = 1'b1;
          if (bit_idx_q == IDX_LAST) state_d = STOP;
          else bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = WAIT_IDLE;
          // A low stop bit is a framing error: keep the previous byte.
          if (rx) begin
            data_d        = sh_q;
            packet_done_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line is released so a stuck-low line cannot retrigger.
        if (rx) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Directed scoreboard bench for uart_rx.
module tb_uart_rx;

  localparam int unsigned CLKS   = 434;
  localparam int          BIT_NS = 8680;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       serial_dat_in = 1'b1;
  logic       get_bit;
  logic       packet_done;
  logic [7:0] data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Monitor-owned records (written only by the monitor).
  int unsigned cyc = 0;
  logic [7:0]  got_q[$];
  int unsigned gb_t[$];
  int unsigned overlap = 0;
  int unsigned longp   = 0;
  logic        pd_prev = 1'b0;
  logic        gb_prev = 1'b0;

  // Stimulus-owned scoreboard.
  logic [7:0]  exp_q[$];
  int unsigned rd = 0;

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .serial_dat_in (serial_dat_in),
    .get_bit       (get_bit),
    .packet_done   (packet_done),
    .data          (data)
  );

  always #10 clk = ~clk;

  // Record output pulses on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (packet_done) got_q.push_back(data);
    if (get_bit) gb_t.push_back(cyc);
    if (get_bit && packet_done) overlap = overlap + 1;
    if ((packet_done && pd_prev) || (get_bit && gb_prev)) longp = longp + 1;
    pd_prev = packet_done;
    gb_prev = get_bit;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_val, input int bit_ns);
    logic [7:0] v;
    v = b;
    serial_dat_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      serial_dat_in = v[i];
      #(bit_ns);
    end
    serial_dat_in = stop_val;
    #(bit_ns);
    serial_dat_in = 1'b1;
  endtask

  // Pop every pending expectation and compare against received bytes.
  task automatic drain(input string tag);
    logic [7:0] e;
    int unsigned waited;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (got_q.size() <= rd && waited < 4 * CLKS) begin
        @(negedge clk);
        waited++;
      end
      if (got_q.size() <= rd) begin
        chk({tag, "_timeout"}, 32'(got_q.size()), 32'(rd + 1));
      end else begin
        chk(tag, 32'(got_q[rd]), 32'(e));
        rd++;
      end
    end
  endtask

  initial begin
    int unsigned gb0, gots;
    logic [7:0] c3;

    // Reset
    rstn = 1'b0;
    serial_dat_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_get_bit", 32'(get_bit), 32'h0);
    chk("rst_packet_done", 32'(packet_done), 32'h0);
    rstn = 1'b1;
    repeat (20) @(negedge clk);

    // Single frame 0x61
    gb0 = gb_t.size();
    exp_q.push_back(8'h61);
    send_byte(8'h61, 1'b1, BIT_NS);
    drain("byte_61");
    chk("gb_count_61", 32'(gb_t.size() - gb0), 32'd8);
    for (int k = 1; k < 8; k++)
      if (gb0 + k < gb_t.size())
        chk("gb_gap_61", gb_t[gb0 + k] - gb_t[gb0 + k - 1], CLKS);
    #(BIT_NS);
    chk("data_hold_61", 32'(data), 32'h61);

    // Back-to-back frames
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hA5);
    send_byte(8'h00, 1'b1, BIT_NS);
    send_byte(8'hFF, 1'b1, BIT_NS);
    send_byte(8'hA5, 1'b1, BIT_NS);
    drain("b2b");
    #(BIT_NS);

    // Short low glitch on idle line
    gb0  = gb_t.size();
    gots = got_q.size();
    serial_dat_in = 1'b0;
    repeat (100) @(negedge clk);
    serial_dat_in = 1'b1;
    repeat (1000) @(negedge clk);
    chk("glitch_gb", 32'(gb_t.size()), 32'(gb0));
    chk("glitch_pd", 32'(got_q.size()), 32'(gots));
    chk("glitch_data", 32'(data), 32'hA5);

    // Framing error, then recovery
    gb0  = gb_t.size();
    gots = got_q.size();
    send_byte(8'h3C, 1'b0, BIT_NS);
    #(2 * BIT_NS);
    chk("ferr_gb", 32'(gb_t.size() - gb0), 32'd8);
    chk("ferr_pd", 32'(got_q.size()), 32'(gots));
    chk("ferr_data", 32'(data), 32'hA5);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, BIT_NS);
    drain("after_ferr");
    #(BIT_NS);

    // Reset during data bit 4 of 0xC3
    c3 = 8'hC3;
    gots = got_q.size();
    serial_dat_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      serial_dat_in = c3[i];
      #(BIT_NS);
    end
    serial_dat_in = c3[4];
    #(BIT_NS / 2);
    @(negedge clk);
    rstn = 1'b0;
    serial_dat_in = 1'b1;
    @(negedge clk);
    chk("midrst_data", 32'(data), 32'h00);
    chk("midrst_get_bit", 32'(get_bit), 32'h0);
    chk("midrst_packet_done", 32'(packet_done), 32'h0);
    rstn = 1'b1;
    #(2 * BIT_NS);
    chk("midrst_no_pd", 32'(got_q.size()), 32'(gots));
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, BIT_NS);
    drain("after_rst");
    #(BIT_NS);

    // Baud skew +-2%
    exp_q.push_back(8'h61);
    send_byte(8'h61, 1'b1, 8506);
    drain("skew_fast");
    #(BIT_NS);
    exp_q.push_back(8'h61);
    send_byte(8'h61, 1'b1, 8854);
    drain("skew_slow");
    #(BIT_NS);
    chk("skew_data", 32'(data), 32'h61);

    // Pulse shape
    chk("pulse_overlap", overlap, 32'd0);
    chk("pulse_width", longp, 32'd0);
    chk("extra_packets", 32'(got_q.size()), 32'(rd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
